seg_scan_ctrl: RTL

Time-multiplexing controller for the Basys-3 four-digit seven-segment display in the calculator. It shares the single segment/decimal-point bus among four digits. Each digit slot is paced by an internal prescaler tick, and a blanking dead-time is inserted between slots to suppress ghosting. It also provides per-digit enable and blink masking, and sits between the calculator result/formatting logic and the board pins.

---
 rtl/seg_scan_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// Four-digit seven-segment scanner with per-slot blanking dead-time, digit enable and blink masking.
// Registered outputs change on the transition edge; no backpressure, en=0 freezes all counters and blanks.
module seg_scan_ctrl #(
   parameter int TICK_DIV  = 100000,
   parameter int DEAD_CYC  = 16,
   parameter int BLINK_DIV = 250
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [15:0] digits,
   input  logic [3:0]  dp_in,
   input  logic [3:0]  digit_en,
   input  logic [3:0]  blink_mask,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [1:0]  scan_idx
);
   localparam int PW = $clog2(TICK_DIV);
   localparam int DW = $clog2(DEAD_CYC + 1);
   localparam int BW = $clog2(BLINK_DIV + 1);
   localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
   localparam logic [DW-1:0] D_LAST = DW'(DEAD_CYC - 1);
   localparam logic [BW-1:0] B_LAST = BW'(BLINK_DIV - 1);

   typedef enum logic {DEAD, SHOW} state_t;

   state_t          state, state_nxt;
   logic [PW-1:0]   pcnt;
   logic [DW-1:0]   dcnt, dcnt_nxt;
   logic [BW-1:0]   bcnt;
   logic            blink_off;
   logic            held;
   logic [3:0]      lat_nib;
   logic            lat_dp, lat_en, lat_bm;
   logic            tick, latch;
   logic [3:0]      src_nib;
   logic            src_dp, src_en, src_bm;
   logic [3:0]      an_nxt;
   logic [6:0]      seg_nxt;
   logic            dp_nxt;

   function automatic logic [6:0] hex7(input logic [3:0] v);
      case (v)
         4'h0: hex7 = 7'h40;
         4'h1: hex7 = 7'h79;
         4'h2: hex7 = 7'h24;
         4'h3: hex7 = 7'h30;
         4'h4: hex7 = 7'h19;
         4'h5: hex7 = 7'h12;
         4'h6: hex7 = 7'h02;
         4'h7: hex7 = 7'h78;
         4'h8: hex7 = 7'h00;
         4'h9: hex7 = 7'h10;
         4'hA: hex7 = 7'h08;
         4'hB: hex7 = 7'h03;
         4'hC: hex7 = 7'h46;
         4'hD: hex7 = 7'h21;
         4'hE: hex7 = 7'h06;
         4'hF: hex7 = 7'h0E;
      endcase
   endfunction

   assign tick = en && (pcnt == P_LAST);

   always_comb begin
      state_nxt = state;
      dcnt_nxt  = dcnt;
      latch     = 1'b0;
      if (en) begin
         if (tick) begin
            state_nxt = DEAD;
            dcnt_nxt  = '0;
         end else if (state == SHOW && held) begin
            // resuming from a pause mid-slot re-runs the dead-time before relighting
            state_nxt = DEAD;
            dcnt_nxt  = '0;
         end else if (state == DEAD) begin
            if (dcnt == D_LAST) begin
               state_nxt = SHOW;
               latch     = 1'b1;
            end else begin
               dcnt_nxt = dcnt + 1'b1;
            end
         end
      end

      src_nib = latch ? digits[{scan_idx, 2'b00} +: 4] : lat_nib;
      src_dp  = latch ? dp_in[scan_idx]      : lat_dp;
      src_en  = latch ? digit_en[scan_idx]   : lat_en;
      src_bm  = latch ? blink_mask[scan_idx] : lat_bm;

      an_nxt  = 4'hF;
      seg_nxt = 7'h7F;
      dp_nxt  = 1'b1;
      if (en && state_nxt == SHOW) begin
         seg_nxt = hex7(src_nib);
         dp_nxt  = ~src_dp;
         if (src_en && !(src_bm && blink_off))
            an_nxt = ~(4'b0001 << scan_idx);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= DEAD;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pcnt      <= '0;
         dcnt      <= '0;
         bcnt      <= '0;
         scan_idx  <= 2'd0;
         blink_off <= 1'b0;
         held      <= 1'b0;
         lat_nib   <= 4'h0;
         lat_dp    <= 1'b0;
         lat_en    <= 1'b0;
         lat_bm    <= 1'b0;
         an        <= 4'hF;
         seg       <= 7'h7F;
         dp        <= 1'b1;
      end else begin
         held <= ~en;
         dcnt <= dcnt_nxt;
         an   <= an_nxt;
         seg  <= seg_nxt;
         dp   <= dp_nxt;
         if (en)
            pcnt <= (pcnt == P_LAST) ? '0 : pcnt + 1'b1;
         if (tick) begin
            scan_idx <= scan_idx + 2'd1;
            if (bcnt == B_LAST) begin
               bcnt      <= '0;
               blink_off <= ~blink_off;
            end else begin
               bcnt <= bcnt + 1'b1;
            end
         end
         if (latch) begin
            lat_nib <= src_nib;
            lat_dp  <= src_dp;
            lat_en  <= src_en;
            lat_bm  <= src_bm;
         end
      end
   end
endmodule
